mem_port_arbiter: RTL and testbench

Shares the single memory port between the core's fetch stage (read-only) and its execute stage (load/store). It runs one outstanding transaction at a time, arbitrates with data-priority plus a fetch anti-starvation limit, and drops fetch responses made stale by a branch-mispredict flush. It sits between the pipeline stages and the memory model; the `pc`/`addr` values are word addresses, as in the core.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and helpers for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP} arb_state_t;

  typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  localparam int unsigned MAX_WAIT_DEFAULT = 4;

  // Data wins a conflict unless fetch has already lost MAX_WAIT in a row.
  function automatic logic fetch_wins(input logic i_req, input logic d_req, input logic at_limit);
    return i_req && (!d_req || at_limit);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory port signal bundle
interface mem_port_arbiter_if;

  // Fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_kill;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  // Data (load/store) port
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  // Memory port
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  // Statistics
  logic [31:0] conflicts;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, i_kill,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rvalid, m_rdata,
    output conflicts
  );

  // Pipeline and memory side
  modport master (
    output i_req, i_addr, i_kill,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_wstrb,
    output m_ready, m_rvalid, m_rdata,
    input  conflicts
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding memory port shared by fetch and load/store
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned      SW    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0]    LIMIT = SW'(MAX_WAIT);

  arb_state_t     state;
  arb_owner_t     owner;
  mem_req_t       req_q;
  logic [SW-1:0]  starve_cnt;
  logic           kill_pending;

  logic idle;
  logic at_limit;
  logic fetch_win;
  logic kill_hit;

  // Grants are combinational but only ever offered from IDLE and never during reset.
  assign idle      = (state == ARB_IDLE) && !rst;
  assign at_limit  = (starve_cnt == LIMIT);
  assign fetch_win = fetch_wins(bus.i_req, bus.d_req, at_limit);
  assign kill_hit  = bus.i_kill && (owner == OWN_FETCH);

  assign bus.i_gnt = idle && fetch_win;
  assign bus.d_gnt = idle && bus.d_req && !fetch_win;

  assign bus.m_we    = req_q.we;
  assign bus.m_addr  = req_q.addr;
  assign bus.m_wdata = req_q.wdata;
  assign bus.m_wstrb = req_q.wstrb;

  // Arbitration FSM: grant in IDLE, present request in REQ, collect response in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ARB_IDLE;
      owner         <= OWN_FETCH;
      req_q         <= '0;
      starve_cnt    <= '0;
      kill_pending  <= 1'b0;
      bus.m_req     <= 1'b0;
      bus.i_rvalid  <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_rvalid  <= 1'b0;
      bus.d_rdata   <= '0;
      bus.conflicts <= '0;
    end else begin
      bus.i_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (bus.i_req && bus.d_req) begin
            bus.conflicts <= bus.conflicts + 32'd1;
          end
          if (bus.i_gnt) begin
            owner      <= OWN_FETCH;
            starve_cnt <= '0;
            req_q      <= '{we: 1'b0, addr: bus.i_addr, wdata: 32'd0, wstrb: 4'd0};
            bus.m_req  <= 1'b1;
            state      <= ARB_REQ;
          end else if (bus.d_gnt) begin
            owner <= OWN_DATA;
            if (bus.i_req && !at_limit) begin
              starve_cnt <= starve_cnt + SW'(1);
            end
            req_q     <= '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata, wstrb: bus.d_wstrb};
            bus.m_req <= 1'b1;
            state     <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (kill_hit) begin
            kill_pending <= 1'b1;
          end
          if (bus.m_ready) begin
            bus.m_req <= 1'b0;
            state     <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (bus.m_rvalid) begin
            state        <= ARB_IDLE;
            kill_pending <= 1'b0;
            if (owner == OWN_DATA) begin
              bus.d_rvalid <= 1'b1;
              bus.d_rdata  <= req_q.we ? 32'd0 : bus.m_rdata;
            end else if (!(kill_pending || bus.i_kill)) begin
              // A flush arriving alongside the response still makes it stale.
              bus.i_rvalid <= 1'b1;
              bus.i_rdata  <= bus.m_rdata;
            end
          end else if (kill_hit) begin
            kill_pending <= 1'b1;
          end
        end
        default: begin
          state     <= ARB_IDLE;
          bus.m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 4;

  typedef struct packed {
    logic        is_data;
    logic [31:0] data;
  } resp_t;

  logic clk;
  logic rst;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stimulus knobs (written by the main sequence only)
  bit          en_i;
  bit          en_d;
  int unsigned rate_i;
  int unsigned rate_d;
  bit          hold_ready;
  int          tmo_cnt;
  int          snap_id;
  logic        snap_pre;
  logic [4:0]  snap_post;

  // Reference model state (written by the model process only)
  bit          m_busy;
  bit          m_accepted;
  bit          m_owner_data;
  bit          m_killed;
  int          m_starve;
  logic [31:0] m_conflicts;
  logic [68:0] m_exp_req;
  resp_t       resp_q[$];

  // Checker counters
  int errs;
  int checks;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Fetch requester: holds each request until granted, occasionally flushes.
  initial begin
    bit i_taken;
    i_taken    = 1'b0;
    bus.i_req  = 1'b0;
    bus.i_addr = '0;
    bus.i_kill = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus.i_req || i_taken) begin
        if (en_i && ($urandom_range(0, 99) < rate_i)) begin
          bus.i_req  = 1'b1;
          bus.i_addr = $urandom;
        end else begin
          bus.i_req = 1'b0;
        end
      end
      bus.i_kill = en_i && ($urandom_range(0, 99) < 8);
      #1;
      i_taken = bus.i_req && bus.i_gnt;
    end
  end

  // Data requester: random loads and stores, held until granted.
  initial begin
    bit d_taken;
    d_taken     = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_wstrb = '0;
    forever begin
      @(negedge clk);
      if (!bus.d_req || d_taken) begin
        if (en_d && ($urandom_range(0, 99) < rate_d)) begin
          bus.d_req   = 1'b1;
          bus.d_we    = 1'($urandom_range(0, 1));
          bus.d_addr  = $urandom;
          bus.d_wdata = $urandom;
          bus.d_wstrb = 4'($urandom);
        end else begin
          bus.d_req = 1'b0;
        end
      end
      #1;
      d_taken = bus.d_req && bus.d_gnt;
    end
  end

  // Memory model: random accept/response stalls, stray strobes outside the
  // states that honour them, and one late response after a reset mid-transaction.
  initial begin
    bit macc, late, saw_req, gave_ready, gave_rvalid;
    int stall;
    macc = 0; late = 0; saw_req = 0; gave_ready = 0; gave_rvalid = 0; stall = 0;
    bus.m_ready  = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b0;
        if (macc || saw_req) late = 1;
        macc = 0; saw_req = 0; gave_ready = 0; gave_rvalid = 0; stall = 0;
      end else begin
        if (gave_ready) macc = 1;
        if (gave_rvalid) macc = 0;
        gave_ready   = 0;
        gave_rvalid  = 0;
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = $urandom;
        if (late) begin
          bus.m_rvalid = 1'b1;
          late = 0;
        end else if (macc) begin
          if ($urandom_range(0, 99) < 50) begin
            bus.m_rvalid = 1'b1;
            gave_rvalid  = 1;
          end
        end else if (bus.m_req) begin
          if (!saw_req && ($urandom_range(0, 99) < 25)) stall = 5;
          if (stall > 0) begin
            stall--;
          end else if (!hold_ready && ($urandom_range(0, 99) < 60)) begin
            bus.m_ready = 1'b1;
            gave_ready  = 1;
          end
        end
        if (!bus.m_req && ($urandom_range(0, 99) < 10)) bus.m_ready = 1'b1;
        if (!macc && !bus.m_rvalid && ($urandom_range(0, 99) < 10)) bus.m_rvalid = 1'b1;
        saw_req = bus.m_req;
      end
    end
  end

  // Transaction-level reference: one transaction at a time, data priority with
  // a fetch starvation limit, flushes invalidate outstanding fetches.
  initial begin
    bit fw;
    m_busy = 0; m_accepted = 0; m_owner_data = 0; m_killed = 0; m_starve = 0;
    m_conflicts = '0; m_exp_req = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 0; m_accepted = 0; m_killed = 0; m_starve = 0; m_conflicts = '0;
      end else if (m_busy) begin
        if (!m_owner_data && bus.i_kill) m_killed = 1;
        if (!m_accepted) begin
          if (bus.m_ready) m_accepted = 1;
        end else if (bus.m_rvalid) begin
          if (m_owner_data) resp_q.push_back('{1'b1, m_exp_req[68] ? 32'd0 : bus.m_rdata});
          else if (!m_killed) resp_q.push_back('{1'b0, bus.m_rdata});
          m_busy = 0; m_accepted = 0; m_killed = 0;
        end
      end else begin
        if (bus.i_req && bus.d_req) m_conflicts = m_conflicts + 32'd1;
        if (bus.i_req || bus.d_req) begin
          fw = bus.i_req && (!bus.d_req || (m_starve == MAX_WAIT));
          if (fw) begin
            m_starve     = 0;
            m_owner_data = 0;
            m_exp_req    = {1'b0, bus.i_addr, 32'd0, 4'd0};
          end else begin
            if (bus.i_req && (m_starve < MAX_WAIT)) m_starve++;
            m_owner_data = 1;
            m_exp_req    = {bus.d_we, bus.d_addr, bus.d_wdata, bus.d_wstrb};
          end
          m_busy = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input bit ok, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the model every cycle and pops the
  // response scoreboard whenever a response strobe appears.
  initial begin
    int snap_seen, tmo_seen;
    logic [1:0]   exp_g;
    logic [127:0] act_v, exp_v;
    resp_t        r;
    snap_seen = 0; tmo_seen = 0; errs = 0; checks = 0;
    forever begin
      @(negedge clk);
      #2;
      if (snap_id != snap_seen) begin
        chk("async_reset_drop", {snap_pre, snap_post} == 6'b100000,
            128'({snap_pre, snap_post}), 128'(6'b100000));
        snap_seen = snap_id;
      end
      if (tmo_cnt != tmo_seen) begin
        chk("wait_timeout", 1'b0, 128'(tmo_cnt), 128'(tmo_seen));
        tmo_seen = tmo_cnt;
      end
      if (rst) begin
        act_v = 128'({bus.i_gnt, bus.i_rvalid, bus.d_gnt, bus.d_rvalid, bus.m_req, bus.m_we,
                      bus.m_wstrb, bus.i_rdata, bus.d_rdata});
        chk("reset_ctrl", act_v == '0, act_v, '0);
        act_v = 128'({bus.m_addr, bus.m_wdata, bus.conflicts});
        chk("reset_data", act_v == '0, act_v, '0);
        resp_q.delete();
      end else begin
        exp_g[1] = !m_busy && bus.i_req && (!bus.d_req || (m_starve == MAX_WAIT));
        exp_g[0] = !m_busy && bus.d_req && !exp_g[1];
        chk("grant", {bus.i_gnt, bus.d_gnt} == exp_g, 128'({bus.i_gnt, bus.d_gnt}), 128'(exp_g));
        if (m_busy && !m_accepted) begin
          act_v = 128'({bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wstrb});
          exp_v = 128'({1'b1, m_exp_req});
          chk("mem_request", act_v == exp_v, act_v, exp_v);
        end else begin
          chk("mem_idle", bus.m_req == 1'b0, 128'(bus.m_req), 128'(0));
        end
        chk("conflicts", bus.conflicts == m_conflicts, 128'(bus.conflicts), 128'(m_conflicts));
        if (bus.i_rvalid || bus.d_rvalid) begin
          if (resp_q.size() == 0) begin
            chk("unexpected_rvalid", 1'b0, 128'({bus.i_rvalid, bus.d_rvalid}), 128'(0));
          end else begin
            r = resp_q.pop_front();
            act_v = 128'({bus.i_rvalid, bus.d_rvalid, r.is_data ? bus.d_rdata : bus.i_rdata});
            exp_v = 128'({!r.is_data, r.is_data, r.data});
            chk("response", act_v == exp_v, act_v, exp_v);
          end
        end else if (resp_q.size() != 0) begin
          r = resp_q.pop_front();
          chk("missing_rvalid", 1'b0, 128'(0), 128'({!r.is_data, r.is_data, r.data}));
        end
      end
    end
  end

  task automatic drain();
    bit quiet;
    en_i  = 0;
    en_d  = 0;
    quiet = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      #3;
      if (!bus.i_req && !bus.d_req && !m_busy) begin
        quiet = 1;
        break;
      end
    end
    if (!quiet) tmo_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    en_i = 0; en_d = 0; rate_i = 0; rate_d = 0; hold_ready = 0;
    tmo_cnt = 0; snap_id = 0; snap_pre = 1'b0; snap_post = '0;
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;

    // Both requesters saturated: exercises the starvation limit.
    rate_i = 100; rate_d = 100; en_i = 1; en_d = 1;
    repeat (150) @(negedge clk);

    // Mixed random traffic.
    rate_i = 50; rate_d = 60;
    repeat (1500) @(negedge clk);
    drain();

    // Reset while a request is held in REQ.
    hold_ready = 1;
    en_d = 1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #3;
      if (bus.m_req) break;
    end
    if (!bus.m_req) tmo_cnt++;
    en_d = 0;
    @(posedge clk);
    #3;
    snap_pre = bus.m_req;
    rst = 1'b1;
    #1;
    snap_post = {bus.m_req, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid};
    snap_id++;
    repeat (2) @(negedge clk);
    #3;
    rst = 1'b0;
    hold_ready = 0;
    repeat (3) @(negedge clk);

    // Traffic resumes from IDLE after reset.
    en_i = 1; en_d = 1;
    repeat (300) @(negedge clk);
    drain();
    repeat (3) @(negedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
